// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: instruction width, PC stride, NOP encoding, FIFO entry.
// No logic of its own; pc_legal is a pure combinational helper.
// Not applicable: no handshake lives here.
package riscv_pkg;

    localparam int          ILEN    = 32;
    localparam logic [31:0] PC_STEP = 32'd4;
    localparam logic [31:0] INS_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] ins;
        logic [ILEN-1:0] pc;
    } fetch_entry_t;

    // Aligned word whose last byte is inside memory; 33-bit sum so a PC near 2^32 cannot wrap into range.
    function automatic logic pc_legal(input logic [31:0] pc, input int unsigned mem_bytes);
        logic [32:0] last_byte;
        last_byte = {1'b0, pc} + 33'd3;
        return (pc[1:0] == 2'b00) && (last_byte < {1'b0, mem_bytes});
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, execute redirect, decode valid/ready, fault.
// Wires only, no latency.
// Decode applies backpressure through out_ready; redirect has no handshake.
interface fetch_unit_if
    import riscv_pkg::*;
();
    logic [ILEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_data;
    logic            redirect_valid;
    logic [ILEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_ins;
    logic [ILEN-1:0] out_pc;
    logic            fault;

    modport master (
        output imem_addr, out_valid, out_ins, out_pc, fault,
        input  imem_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_ins, out_pc, fault,
        output imem_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of {ins, pc} entries with synchronous clear; head is the oldest entry.
// Push visible at the head one cycle later; head/count are registered state.
// Caller must not push when full unless it pops in the same cycle; clr overrides push and pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    output fetch_entry_t head_dat,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next-state for storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; storage is zeroed on reset so the head reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory, queues {ins, pc} for decode, flags illegal PCs.
// Fetch in cycle N appears at out_* in N+1 when the queue was empty; one instruction per cycle sustained.
// out_ready low fills the queue and stalls the PC; a full queue still fetches when decode pops that cycle.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned MEM_BYTES = 400,
    parameter int          DEPTH     = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic          fault_q, fault_d;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_dat;
    logic          out_valid;
    logic          pc_ok;
    logic          deq;
    logic          fetch;

    assign out_valid = (count != '0);
    assign pc_ok     = pc_legal(pc_q, MEM_BYTES);
    assign deq       = out_valid && bus.out_ready;
    assign fetch     = !bus.redirect_valid && !fault_q && pc_ok
                       && ((count < CW'(DEPTH)) || deq);

    assign push_dat.ins = bus.imem_data;
    assign push_dat.pc  = pc_q;

    // PC and fault update: redirect beats fetch; an illegal PC that is not being redirected latches fault.
    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            fault_d = 1'b0;
        end else if (fetch) begin
            pc_d = pc_q + PC_STEP;
        end else if (!pc_ok && !fault_q) begin
            fault_d = 1'b1;
        end
    end

    // PC and fault registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Redirect flushes the queue; a pop in the same cycle is simply discarded with everything else.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.redirect_valid),
        .push     (fetch),
        .push_dat (push_dat),
        .pop      (deq),
        .head_dat (head),
        .count    (count)
    );

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = out_valid;
    assign bus.out_ins   = head.ins;
    assign bus.out_pc    = head.pc;
    assign bus.fault     = fault_q;

endmodule
